// File: rtl/ibex_bus_responder_pkg.sv
// Shared types and integrity-code constants for the Ibex bus responder.
package ibex_bus_responder_pkg;

    localparam int unsigned IntgW = 7;
    localparam logic [IntgW-1:0] IntgInvMask = 7'h2A;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Hsiao (39,32) parity-check rows, one per check bit.
    function automatic logic [31:0] intg_mask(input int unsigned i);
        case (i)
            0:       intg_mask = 32'h2606_BD25;
            1:       intg_mask = 32'hDEBA_8050;
            2:       intg_mask = 32'h413D_89AA;
            3:       intg_mask = 32'h3123_4ED1;
            4:       intg_mask = 32'hC2C1_323B;
            5:       intg_mask = 32'h2DCC_624C;
            6:       intg_mask = 32'h9850_5586;
            default: intg_mask = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/ibex_bus_intg_enc.sv
// Combinational 32->7 inverted Hsiao SECDED encoder.
module ibex_bus_intg_enc
    import ibex_bus_responder_pkg::*;
(
    input  logic [31:0]      i_data,
    output logic [IntgW-1:0] o_intg
);

    always_comb begin
        o_intg = '0;
        for (int unsigned i = 0; i < IntgW; i++) begin
            o_intg[i] = (^(i_data & intg_mask(i))) ^ IntgInvMask[i];
        end
    end

endmodule

// File: rtl/ibex_bus_responder.sv
// Memory-side req/gnt/rvalid responder: byte-enable RAM, grant delay,
// fixed-latency response pipeline with error and integrity outputs.
module ibex_bus_responder
    import ibex_bus_responder_pkg::*;
#(
    parameter int unsigned MemWords   = 1024,
    parameter logic [31:0] BaseAddr   = 32'h0010_0000,
    parameter int unsigned GntDelay   = 0,
    parameter int unsigned RspLatency = 1,
    parameter bit          CheckWIntg = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IntgW-1:0] wdata_intg_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic [IntgW-1:0] rdata_intg_o,
    output logic             err_o
);

    localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam logic [31:0] EndAddr = BaseAddr + 32'(4 * MemWords);

    logic [3:0]       r_cnt;
    logic [31:0]      r_mem [MemWords];
    rsp_t             r_pipe [RspLatency];

    logic             w_gnt;
    logic             w_in_range;
    logic             w_intg_bad;
    logic             w_err;
    logic             w_wr_en;
    logic [IdxW-1:0]  w_idx;
    logic [IntgW-1:0] w_wintg;
    rsp_t             w_rsp;
    rsp_t             w_out;

    // Grant is suppressed while reset is asserted.
    assign w_gnt = req_i && !rst_i && (r_cnt == 4'(GntDelay));
    assign gnt_o = w_gnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || w_gnt) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign w_in_range = (addr_i >= BaseAddr) && (addr_i < EndAddr);
    assign w_idx      = IdxW'((addr_i - BaseAddr) >> 2);

    ibex_bus_intg_enc u_wenc (
        .i_data (wdata_i),
        .o_intg (w_wintg)
    );

    assign w_intg_bad = CheckWIntg && (w_wintg != wdata_intg_i);
    assign w_err      = !w_in_range || (we_i && w_intg_bad);
    assign w_wr_en    = w_gnt && we_i && !w_err;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Idle stages carry all-zero so the outputs read 0 without gating.
    always_comb begin
        w_rsp = '0;
        if (w_gnt) begin
            w_rsp.valid = 1'b1;
            w_rsp.err   = w_err;
            if (!we_i && !w_err) begin
                w_rsp.rdata = r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RspLatency; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rsp;
            for (int i = 1; i < RspLatency; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out    = r_pipe[RspLatency-1];
    assign rvalid_o = w_out.valid;
    assign rdata_o  = w_out.rdata;
    assign err_o    = w_out.err;

    ibex_bus_intg_enc u_renc (
        .i_data (rdata_o),
        .o_intg (rdata_intg_o)
    );

endmodule

// File: tb/tb_ibex_bus_responder.sv
// Self-checking bench for ibex_bus_responder across three configurations.
module tb_ibex_bus_responder;

    localparam logic [31:0] B = 32'h0010_0000;

    logic        clk;
    logic        rst    [3];
    logic        req    [3];
    logic        gnt    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [6:0]  wintg  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic [6:0]  rintg  [3];
    logic        err    [3];

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] mdl [3][16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ibex_bus_responder #(
            .MemWords   (1024),
            .BaseAddr   (B),
            .GntDelay   (g == 1 ? 3 : 0),
            .RspLatency (g == 1 ? 3 : (g == 2 ? 2 : 1)),
            .CheckWIntg (g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst[g]),
            .req_i        (req[g]),
            .gnt_o        (gnt[g]),
            .we_i         (we[g]),
            .be_i         (be[g]),
            .addr_i       (addr[g]),
            .wdata_i      (wdata[g]),
            .wdata_intg_i (wintg[g]),
            .rvalid_o     (rvalid[g]),
            .rdata_o      (rdata[g]),
            .rdata_intg_o (rintg[g]),
            .err_o        (err[g])
        );
    end

    function automatic int gd(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int lat(input int k);
        return (k == 1) ? 3 : ((k == 2) ? 2 : 1);
    endfunction

    function automatic bit chkw(input int k);
        return k != 2;
    endfunction

    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [31:0] m [7];
        logic [6:0]  r;
        m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
              32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
        for (int i = 0; i < 7; i++) r[i] = ^(d & m[i]);
        return r ^ 7'h2A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic xact(input int k, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [6:0] ig,
                        output logic [31:0] rd, output logic [6:0] ri,
                        output logic e, output int gw, output int rw);
        req[k] = 1'b1; we[k] = w; be[k] = b;
        addr[k] = a; wdata[k] = d; wintg[k] = ig;
        gw = 0;
        #1;
        while (!gnt[k] && gw < 40) begin
            tick(); #1; gw++;
        end
        tick();
        req[k] = 1'b0;
        rw = 1;
        #1;
        while (!rvalid[k] && rw < 20) begin
            tick(); #1; rw++;
        end
        rd = rdata[k]; ri = rintg[k]; e = err[k];
        tick();
    endtask

    task automatic chk_tx(input string nm, input int k,
                          input logic [31:0] rd, input logic [6:0] ri,
                          input logic e, input int gw, input int rw,
                          input logic [31:0] xrd, input logic xe);
        chk({nm, ".rdata"}, rd, xrd);
        chk({nm, ".err"}, 32'(e), 32'(xe));
        chk({nm, ".intg"}, 32'(ri), 32'(enc(xrd)));
        chk({nm, ".gnt_wait"}, 32'(gw), 32'(gd(k)));
        chk({nm, ".rsp_lat"}, 32'(rw), 32'(lat(k)));
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  flip;
        logic [31:0] xrd;
        logic        xe;
    } vec_t;

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        vec_t        v [$];
        logic [31:0] rd;
        logic [6:0]  ri;
        logic        e;
        int          gw, rw;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0;
            addr[k] = B; wdata[k] = '0; wintg[k] = enc(32'h0);
        end
        req[0] = 1'b1;
        tick();

        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rst%0d.gnt", c), 32'(gnt[0]), 32'h0);
            chk($sformatf("rst%0d.rvalid", c), 32'(rvalid[0]), 32'h0);
            chk($sformatf("rst%0d.rdata", c), rdata[0], 32'h0);
            chk($sformatf("rst%0d.intg", c), 32'(rintg[0]), 32'h2A);
            tick();
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1;
        chk("post_rst.gnt", 32'(gnt[0]), 32'h1);
        chk("post_rst.rvalid", 32'(rvalid[0]), 32'h0);
        tick();
        req[0] = 1'b0;
        #1;
        chk("post_rst.rsp", 32'(rvalid[0]), 32'h1);
        tick();

        v.push_back('{1'b1, 4'hF, B,           32'hDEADBEEF, 7'h0, 32'h0,        1'b0});
        v.push_back('{1'b0, 4'hF, B,           32'h0,        7'h0, 32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 4'h5, B,           32'h11223344, 7'h0, 32'h0,        1'b0});
        v.push_back('{1'b0, 4'hF, B,           32'h0,        7'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b0, 4'hF, B + 32'h1000, 32'h0,       7'h0, 32'h0,        1'b1});
        v.push_back('{1'b1, 4'hF, 32'h000F_FFFC, 32'h12345678, 7'h0, 32'h0,      1'b1});
        v.push_back('{1'b0, 4'hF, B,           32'h0,        7'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b1, 4'hF, B,           32'hCAFEF00D, 7'h8, 32'h0,        1'b1});
        v.push_back('{1'b0, 4'hF, B,           32'h0,        7'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b1, 4'hF, B + 4,       32'hA5A5A5A5, 7'h0, 32'h0,        1'b0});
        v.push_back('{1'b1, 4'h0, B + 4,       32'h55555555, 7'h0, 32'h0,        1'b0});
        v.push_back('{1'b0, 4'hF, B + 4,       32'h0,        7'h0, 32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b1, 4'hF, B + 32'hFFC, 32'h0BADCAFE, 7'h0, 32'h0,        1'b0});
        v.push_back('{1'b0, 4'hF, B + 32'hFFC, 32'h0,        7'h0, 32'h0BADCAFE, 1'b0});
        v.push_back('{1'b0, 4'hF, B + 3,       32'h0,        7'h0, 32'hDE22BE44, 1'b0});
        v.push_back('{1'b0, 4'hF, B + 32'hFFF, 32'h0,        7'h0, 32'h0BADCAFE, 1'b0});

        foreach (v[i]) begin
            xact(0, v[i].we, v[i].be, v[i].addr, v[i].wdata,
                 enc(v[i].wdata) ^ v[i].flip, rd, ri, e, gw, rw);
            chk_tx($sformatf("vec%0d", i), 0, rd, ri, e, gw, rw,
                   v[i].xrd, v[i].xe);
        end

        xact(2, 1'b1, 4'hF, B, 32'hDEADBEEF, enc(32'hDEADBEEF) ^ 7'h08,
             rd, ri, e, gw, rw);
        chk_tx("nochk.wr", 2, rd, ri, e, gw, rw, 32'h0, 1'b0);
        xact(2, 1'b0, 4'hF, B, 32'h0, enc(32'h0), rd, ri, e, gw, rw);
        chk_tx("nochk.rd", 2, rd, ri, e, gw, rw, 32'hDEADBEEF, 1'b0);

        xact(1, 1'b1, 4'hF, B, 32'h12345678, enc(32'h12345678),
             rd, ri, e, gw, rw);
        chk_tx("dly.wr", 1, rd, ri, e, gw, rw, 32'h0, 1'b0);
        xact(1, 1'b0, 4'hF, B, 32'h0, enc(32'h0), rd, ri, e, gw, rw);
        chk_tx("dly.rd", 1, rd, ri, e, gw, rw, 32'h12345678, 1'b0);

        req[1] = 1'b1; we[1] = 1'b0; addr[1] = B;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("midrst.gnt%0d", c), 32'(gnt[1]), 32'(c == 3));
            tick();
        end
        req[1] = 1'b0; rst[1] = 1'b1;
        #1;
        chk("midrst.rv4", 32'(rvalid[1]), 32'h0);
        tick();
        rst[1] = 1'b0;
        for (int c = 5; c < 8; c++) begin
            #1;
            chk($sformatf("midrst.rv%0d", c), 32'(rvalid[1]), 32'h0);
            tick();
        end

        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++) begin
                logic [31:0] d;
                d = $urandom;
                xact(k, 1'b1, 4'hF, B + 32'(4 * w), d, enc(d),
                     rd, ri, e, gw, rw);
                mdl[k][w] = d;
                chk($sformatf("pre%0d_%0d.err", k, w), 32'(e), 32'h0);
            end
        end

        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                req[2] = 1'b1; we[2] = 1'b0; addr[2] = B + 32'(4 * i);
            end else begin
                req[2] = 1'b0;
            end
            #1;
            if (i < 3) chk($sformatf("b2b.gnt%0d", i), 32'(gnt[2]), 32'h1);
            chk($sformatf("b2b.rv%0d", i), 32'(rvalid[2]), 32'(i >= 2));
            if (i >= 2)
                chk($sformatf("b2b.rd%0d", i), rdata[2], mdl[2][i-2]);
            tick();
        end
        #1;
        chk("b2b.rv_end", 32'(rvalid[2]), 32'h0);
        tick();

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                logic        w, inr, xe;
                logic [3:0]  b;
                logic [31:0] a, d, xrd;
                logic [6:0]  ig;
                int          idx;
                w = 1'($urandom);
                b = 4'($urandom);
                d = $urandom;
                if ($urandom_range(0, 99) < 85) begin
                    a = B + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                end else begin
                    case ($urandom_range(0, 3))
                        0:       a = B - 4;
                        1:       a = B + 32'h1000;
                        2:       a = 32'h0;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
                ig = enc(d);
                if ($urandom_range(0, 3) == 0) ig ^= 7'(1 << $urandom_range(0, 6));
                inr = (a >= B) && (a < B + 32'h1000);
                idx = int'((a - B) >> 2);
                xe  = !inr || (w && chkw(k) && (ig != enc(d)));
                xrd = 32'h0;
                if (!xe) begin
                    if (w) begin
                        for (int j = 0; j < 4; j++)
                            if (b[j]) mdl[k][idx][8*j +: 8] = d[8*j +: 8];
                    end else begin
                        xrd = mdl[k][idx];
                    end
                end
                xact(k, w, b, a, d, ig, rd, ri, e, gw, rw);
                chk_tx($sformatf("rnd%0d_%0d", k, n), k, rd, ri, e, gw, rw,
                       xrd, xe);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
